// File: rtl/gshare_if.sv
// Fetch/commit signal bundle between the front end, the ROB and the gshare predictor.
// The master side drives fetch and commit information; the predictor is the slave.
interface gshare_if #(
    parameter int XLEN   = 32,
    parameter int HIST_W = 8
);
    logic [XLEN-1:0]   fet_inst_addr;
    logic              fet_br_valid;
    logic              bp_pred;
    logic [HIST_W-1:0] bp_ghr;
    logic              rob_bp_enable;
    logic [XLEN-1:0]   rob_bp_inst_addr;
    logic [HIST_W-1:0] rob_bp_ghr;
    logic              rob_bp_jump;
    logic              rob_bp_correct;
    logic [XLEN-1:0]   bp_correct_cnt;
    logic [XLEN-1:0]   bp_total_cnt;

    modport master (
        output fet_inst_addr, fet_br_valid,
        output rob_bp_enable, rob_bp_inst_addr, rob_bp_ghr, rob_bp_jump, rob_bp_correct,
        input  bp_pred, bp_ghr, bp_correct_cnt, bp_total_cnt
    );

    modport slave (
        input  fet_inst_addr, fet_br_valid,
        input  rob_bp_enable, rob_bp_inst_addr, rob_bp_ghr, rob_bp_jump, rob_bp_correct,
        output bp_pred, bp_ghr, bp_correct_cnt, bp_total_cnt
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor: saturating-counter table, speculative global
// history with commit-time repair, and saturating accuracy statistics.
module gshare_predictor #(
    parameter int XLEN     = 32,
    parameter int IDX_W    = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter int HIST_W   = 8,
    parameter int ADDR_LSB = 1,
    parameter int MODE     = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    gshare_if.slave  bp
);
    localparam int             DEPTH    = 1 << IDX_W;
    localparam bit             USE_HIST = (MODE != 0);
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

    logic [CTR_W-1:0]  table_q [DEPTH];
    logic [CTR_W-1:0]  table_d [DEPTH];
    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic [XLEN-1:0]   total_q, total_d;
    logic [XLEN-1:0]   correct_q, correct_d;
    logic [IDX_W-1:0]  fet_idx, rob_idx;
    logic              unused_addr_bits;

    function automatic logic [IDX_W-1:0] pc_idx(input logic [XLEN-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    function automatic logic [IDX_W-1:0] hist_ext(input logic [HIST_W-1:0] h);
        return IDX_W'(h);
    endfunction

    // Shift through a HIST_W+1 temporary so HIST_W=1 needs no special case.
    function automatic logic [HIST_W-1:0] hist_shift(input logic [HIST_W-1:0] h, input logic b);
        logic [HIST_W:0] t;
        t = {h, b};
        return t[HIST_W-1:0];
    endfunction

    function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
        return (c == {CTR_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] stat_inc(input logic [XLEN-1:0] c);
        return (c == {XLEN{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign fet_idx = pc_idx(bp.fet_inst_addr) ^ (USE_HIST ? hist_ext(ghr_q) : '0);
    // Commit indexes with the history the branch was predicted under, not the current one.
    assign rob_idx = pc_idx(bp.rob_bp_inst_addr) ^ (USE_HIST ? hist_ext(bp.rob_bp_ghr) : '0);

    assign bp.bp_pred        = table_q[fet_idx][CTR_W-1];
    assign bp.bp_ghr         = ghr_q;
    assign bp.bp_total_cnt   = total_q;
    assign bp.bp_correct_cnt = correct_q;

    assign unused_addr_bits = ^{bp.fet_inst_addr, bp.rob_bp_inst_addr};

    always_comb begin
        table_d   = table_q;
        ghr_d     = ghr_q;
        total_d   = total_q;
        correct_d = correct_q;
        if (rdy) begin
            if (bp.rob_bp_enable) begin
                table_d[rob_idx] = bp.rob_bp_jump ? ctr_inc(table_q[rob_idx])
                                                  : ctr_dec(table_q[rob_idx]);
                total_d = stat_inc(total_q);
                if (bp.rob_bp_correct)
                    correct_d = stat_inc(correct_q);
            end
            // A mispredict flushes younger fetches, so repair wins over a same-cycle shift.
            if (bp.rob_bp_enable && !bp.rob_bp_correct)
                ghr_d = hist_shift(bp.rob_bp_ghr, bp.rob_bp_jump);
            else if (bp.fet_br_valid)
                ghr_d = hist_shift(ghr_q, bp.bp_pred);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                table_q[i] <= CTR_RST;
            ghr_q     <= '0;
            total_q   <= '0;
            correct_q <= '0;
        end else begin
            table_q   <= table_d;
            ghr_q     <= ghr_d;
            total_q   <= total_d;
            correct_q <= correct_d;
        end
    end
endmodule

// File: tb/tb_gshare_predictor.sv
// Randomized and directed bench for gshare_predictor against a table/array reference model.
module tb_gshare_predictor;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic rdy_s;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    gshare_if #(.XLEN(32), .HIST_W(4)) if_m ();
    gshare_if #(.XLEN(10), .HIST_W(4)) if_s ();

    gshare_predictor #(.XLEN(32), .IDX_W(8), .CTR_W(2), .CTR_INIT(1), .HIST_W(4),
                       .ADDR_LSB(1), .MODE(1)) dut_m (.clk(clk), .rst(rst), .rdy(rdy), .bp(if_m));

    gshare_predictor #(.XLEN(10), .IDX_W(8), .CTR_W(2), .CTR_INIT(1), .HIST_W(4),
                       .ADDR_LSB(1), .MODE(0)) dut_s (.clk(clk), .rst(rst), .rdy(rdy_s), .bp(if_s));

    // Reference state: gshare instance
    int          m_tbl [256];
    logic [3:0]  m_ghr;
    longint      m_tot, m_cor;
    // Reference state: bimodal small-stats instance (only entry of 0x100 tracked)
    int          s_ctr;
    longint      s_tot, s_cor;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int pidx(input logic [31:0] a);
        return int'((a >> 1) & 32'hFF);
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_tbl[i] = 1;
        m_ghr = 4'h0; m_tot = 0; m_cor = 0;
        s_ctr = 1; s_tot = 0; s_cor = 0;
    endtask

    task automatic step(input bit r, input logic [31:0] fa, input bit fv, input bit en,
                        input logic [31:0] ra, input logic [3:0] rg, input bit rj, input bit rc);
        int  fi, ci;
        bit  ep;
        @(negedge clk);
        rdy = r;
        if_m.fet_inst_addr = fa;    if_m.fet_br_valid = fv;
        if_m.rob_bp_enable = en;    if_m.rob_bp_inst_addr = ra;
        if_m.rob_bp_ghr = rg;       if_m.rob_bp_jump = rj;   if_m.rob_bp_correct = rc;
        #1;
        fi = pidx(fa) ^ int'(m_ghr);
        ep = (m_tbl[fi] >= 2);
        chk("pred", {63'd0, if_m.bp_pred}, {63'd0, ep});
        chk("ghr", {60'd0, if_m.bp_ghr}, {60'd0, m_ghr});
        chk("total", {32'd0, if_m.bp_total_cnt}, m_tot);
        chk("correct", {32'd0, if_m.bp_correct_cnt}, m_cor);
        if (r) begin
            if (en) begin
                ci = pidx(ra) ^ int'(rg);
                m_tbl[ci] = rj ? ((m_tbl[ci] < 3) ? m_tbl[ci] + 1 : 3)
                               : ((m_tbl[ci] > 0) ? m_tbl[ci] - 1 : 0);
                m_tot = sat(m_tot + 1, 64'hFFFF_FFFF);
                if (rc) m_cor = sat(m_cor + 1, 64'hFFFF_FFFF);
            end
            if (en && !rc) m_ghr = {rg[2:0], rj};
            else if (fv)   m_ghr = {m_ghr[2:0], ep};
        end
        @(posedge clk);
    endtask

    task automatic step_s(input bit en, input bit rj, input bit rc, input logic [9:0] ra);
        @(negedge clk);
        if_s.fet_inst_addr = 10'h100;
        if_s.rob_bp_enable = en;  if_s.rob_bp_inst_addr = ra;
        if_s.rob_bp_jump = rj;    if_s.rob_bp_correct = rc;
        #1;
        chk("s_pred", {63'd0, if_s.bp_pred}, {63'd0, (s_ctr >= 2)});
        chk("s_total", {54'd0, if_s.bp_total_cnt}, s_tot);
        chk("s_correct", {54'd0, if_s.bp_correct_cnt}, s_cor);
        if (en) begin
            if (ra == 10'h100)
                s_ctr = rj ? ((s_ctr < 3) ? s_ctr + 1 : 3) : ((s_ctr > 0) ? s_ctr - 1 : 0);
            s_tot = sat(s_tot + 1, 1023);
            if (rc) s_cor = sat(s_cor + 1, 1023);
        end
        @(posedge clk);
    endtask

    task automatic rand_main(input int n);
        for (int i = 0; i < n; i++)
            step(($urandom % 10) != 0, 32'h100 + 2 * $urandom_range(0, 15), $urandom % 2,
                 $urandom % 2, 32'h100 + 2 * $urandom_range(0, 15), 4'($urandom),
                 $urandom % 2, ($urandom % 10) < 7);
    endtask

    initial begin
        longint   sv_tot, sv_cor;
        logic [3:0] sv_ghr;
        rst = 1'b1; rdy = 1'b1; rdy_s = 1'b1;
        if_m.fet_inst_addr = '0; if_m.fet_br_valid = 1'b0; if_m.rob_bp_enable = 1'b0;
        if_m.rob_bp_inst_addr = '0; if_m.rob_bp_ghr = '0; if_m.rob_bp_jump = 1'b0;
        if_m.rob_bp_correct = 1'b0;
        if_s.fet_inst_addr = '0; if_s.fet_br_valid = 1'b0; if_s.rob_bp_enable = 1'b0;
        if_s.rob_bp_inst_addr = '0; if_s.rob_bp_ghr = '0; if_s.rob_bp_jump = 1'b0;
        if_s.rob_bp_correct = 1'b0;
        model_reset();

        // Reset state
        #1;
        for (int i = 0; i < 4; i++) begin
            if_m.fet_inst_addr = 32'h100 + 32'(i * 6);
            #1;
            chk("rst_pred", {63'd0, if_m.bp_pred}, 64'd0);
        end
        chk("rst_ghr", {60'd0, if_m.bp_ghr}, 64'd0);
        chk("rst_total", {32'd0, if_m.bp_total_cnt}, 64'd0);
        chk("rst_correct", {32'd0, if_m.bp_correct_cnt}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;

        // Bimodal counter saturation at addr 0x100
        repeat (3) step_s(1'b1, 1'b1, 1'b1, 10'h100);
        repeat (4) step_s(1'b1, 1'b0, 1'b1, 10'h100);
        step_s(1'b0, 1'b0, 1'b0, 10'h100);
        // Statistics saturation on the 10-bit instance
        for (int i = 0; i < 1040; i++)
            step_s(1'b1, 1'($urandom), (i >= 10), 10'h200);
        step_s(1'b1, 1'b1, 1'b1, 10'h200);
        step_s(1'b0, 1'b0, 1'b0, 10'h200);
        chk("s_total_sat", {54'd0, if_s.bp_total_cnt}, 64'h3FF);
        chk("s_correct_sat", {54'd0, if_s.bp_correct_cnt}, 64'h3FF);
        if_s.rob_bp_enable = 1'b0;

        // Gshare: train entries 0x82, 0x83, 0x81 taken, then shift three predictions
        for (int k = 0; k < 2; k++) begin
            step(1, 32'h0, 0, 1, 32'h104, 4'h0, 1, 1);
            step(1, 32'h0, 0, 1, 32'h106, 4'h0, 1, 1);
            step(1, 32'h0, 0, 1, 32'h102, 4'h0, 1, 1);
        end
        repeat (3) step(1, 32'h104, 1, 0, 32'h0, 4'h0, 0, 1);
        #1;
        chk("ghr_0111", {60'd0, if_m.bp_ghr}, 64'h7);
        chk("pred_e85", {63'd0, if_m.bp_pred}, 64'd0);

        // Mispredict repair beats a same-cycle fetch shift
        sv_tot = m_tot; sv_cor = m_cor;
        step(1, 32'h104, 1, 1, 32'h140, 4'b1010, 0, 0);
        #1;
        chk("repair_ghr", {60'd0, if_m.bp_ghr}, 64'h4);
        chk("repair_total", {32'd0, if_m.bp_total_cnt}, sv_tot + 1);
        chk("repair_correct", {32'd0, if_m.bp_correct_cnt}, sv_cor);

        rand_main(600);

        // rdy low freezes everything
        sv_tot = m_tot; sv_cor = m_cor; sv_ghr = m_ghr;
        for (int i = 0; i < 5; i++)
            step(0, 32'h100 + 2 * $urandom_range(0, 15), 1, 1, 32'h100 + 2 * $urandom_range(0, 15),
                 4'($urandom), 1'($urandom), 1'($urandom));
        step(1, 32'h100, 0, 0, 32'h0, 4'h0, 0, 1);
        chk("frz_ghr", {60'd0, if_m.bp_ghr}, {60'd0, sv_ghr});
        chk("frz_total", {32'd0, if_m.bp_total_cnt}, sv_tot);
        chk("frz_correct", {32'd0, if_m.bp_correct_cnt}, sv_cor);

        // Make sure some entry predicts taken, then reset asynchronously between edges
        repeat (3) step(1, 32'h0, 0, 1, 32'h110, 4'h0, 1, 1);
        if_m.rob_bp_enable = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        if_m.fet_inst_addr = 32'h110; if_m.fet_br_valid = 1'b0;
        #1;
        chk("arst_pred", {63'd0, if_m.bp_pred}, 64'd0);
        chk("arst_ghr", {60'd0, if_m.bp_ghr}, 64'd0);
        chk("arst_total", {32'd0, if_m.bp_total_cnt}, 64'd0);
        chk("arst_correct", {32'd0, if_m.bp_correct_cnt}, 64'd0);
        chk("arst_s_total", {54'd0, if_s.bp_total_cnt}, 64'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;

        rand_main(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
